// File: rtl/rst_ctxt_serializer_if.sv
// Byte-stream and ciphertext-capture signals of the RST ciphertext serializer.
interface rst_ctxt_serializer_if #(
  parameter int unsigned CNT_W = 4
);
  logic [15:0]      ctxt_str;
  logic             ctxt_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] fill_count;
  logic             empty;
  logic             ovf;
  logic             clr_ovf;

  modport master (
    output ctxt_str, ctxt_ready, out_ready, clr_ovf,
    input  out_data, out_valid, fill_count, empty, ovf
  );

  modport slave (
    input  ctxt_str, ctxt_ready, out_ready, clr_ovf,
    output out_data, out_valid, fill_count, empty, ovf
  );
endinterface

// File: rtl/rst_ctxt_serializer.sv
// Buffers 16-bit RST ciphertext pairs in a FIFO and emits them high byte first over valid/ready.
// Optional RST_SER_SEPARATOR_EN appends a space byte (8'h20) after every pair.
module rst_ctxt_serializer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  rst_ctxt_serializer_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

`ifdef RST_SER_SEPARATOR_EN
  localparam logic [7:0] SEP_BYTE = 8'h20;
  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_SEP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;
`endif

  state_t           r_state;
  logic [15:0]      r_mem [DEPTH];
  logic [15:0]      r_hold;
  logic [7:0]       r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_ovf;
  logic             r_empty;

  logic             w_hs;
  logic             w_last;
  logic             w_reload;
  logic             w_fifo_ne;
  logic             w_pop;
  logic             w_push;
  logic             w_to_idle;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      w_head;

  assign w_hs = r_valid & bus.out_ready;
`ifdef RST_SER_SEPARATOR_EN
  assign w_last = (r_state == S_SEP);
`else
  assign w_last = (r_state == S_LO);
`endif
  // Handoff of the final byte of a pair frees the output stage for the next pop.
  assign w_reload   = w_hs & w_last;
  assign w_fifo_ne  = (r_cnt != '0);
  assign w_pop      = w_fifo_ne & ((r_state == S_IDLE) | w_reload);
  assign w_push     = bus.ctxt_ready & ((r_cnt != CNT_W'(DEPTH)) | w_pop);
  assign w_to_idle  = ~w_fifo_ne & ((r_state == S_IDLE) | w_reload);
  assign w_cnt_next = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head     = r_mem[r_rptr];

  // Storage array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.ctxt_str;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= 16'h0000;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovf   <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_next;
      r_empty <= (w_cnt_next == '0) & w_to_idle;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);

      // A drop in the same cycle as a clear leaves the flag set.
      if (bus.ctxt_ready & ~w_push) r_ovf <= 1'b1;
      else if (bus.clr_ovf)         r_ovf <= 1'b0;

      if (w_pop) begin
        r_hold  <= w_head;
        r_data  <= w_head[15:8];
        r_valid <= 1'b1;
        r_state <= S_HI;
      end else if (w_to_idle) begin
        r_data  <= 8'h00;
        r_valid <= 1'b0;
        r_state <= S_IDLE;
      end else if (w_hs) begin
        case (r_state)
          S_HI: begin
            r_data  <= r_hold[7:0];
            r_state <= S_LO;
          end
`ifdef RST_SER_SEPARATOR_EN
          S_LO: begin
            r_data  <= SEP_BYTE;
            r_state <= S_SEP;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.out_data   = r_data;
  assign bus.out_valid  = r_valid;
  assign bus.fill_count = r_cnt;
  assign bus.empty      = r_empty;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_rst_ctxt_serializer.sv
// Directed bench for rst_ctxt_serializer; expectations follow RST_SER_SEPARATOR_EN when defined.
module tb_rst_ctxt_serializer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [7:0] exp_q [$];

  rst_ctxt_serializer_if #(.CNT_W(4)) bus ();

  rst_ctxt_serializer #(.DEPTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pair(input logic [15:0] p);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
`ifdef RST_SER_SEPARATOR_EN
    exp_q.push_back(8'h20);
`endif
  endtask

  // Drains exp_q with out_ready high; every byte must appear on consecutive cycles.
  task automatic collect(input string tag, input int budget);
    int n = 0;
    logic [7:0] b;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(bus.out_valid), 32'd1);
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_byte"}, 32'(bus.out_data), 32'(b));
      tick();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.ctxt_str   = 16'h0000;
    bus.ctxt_ready = 1'b0;
    bus.out_ready  = 1'b0;
    bus.clr_ovf    = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'h00);
    check("rst_fill",  32'(bus.fill_count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_ovf",   32'(bus.ovf), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single pair: latency and byte order
    bus.ctxt_str   = 16'h6162;
    bus.ctxt_ready = 1'b1;
    bus.out_ready  = 1'b1;
    tick();
    bus.ctxt_ready = 1'b0;
    check("t1_fill1",  32'(bus.fill_count), 32'd1);
    check("t1_empty0", 32'(bus.empty), 32'd0);
    check("t1_nvalid", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_valid",  32'(bus.out_valid), 32'd1);
    check("t1_hi",     32'(bus.out_data), 32'h61);
    check("t1_fill0",  32'(bus.fill_count), 32'd0);
    tick();
    check("t1_lo",     32'(bus.out_data), 32'h62);
`ifdef RST_SER_SEPARATOR_EN
    tick();
    check("t1_sep",    32'(bus.out_data), 32'h20);
`endif
    tick();
    check("t1_idle",   32'(bus.out_valid), 32'd0);
    check("t1_empty1", 32'(bus.empty), 32'd1);

    // Back-to-back strobes, no bubble in the output stream
    add_pair(16'h6162);
    add_pair(16'h6768);
    add_pair(16'h3031);
    fork
      begin
        bus.ctxt_ready = 1'b1;
        bus.ctxt_str = 16'h6162; tick();
        bus.ctxt_str = 16'h6768; tick();
        bus.ctxt_str = 16'h3031; tick();
        bus.ctxt_ready = 1'b0;
      end
      collect("b2b", 10);
    join
    check("b2b_empty", 32'(bus.empty), 32'd1);

    // Back-pressure: fill the FIFO, drop the 10th pair
    bus.out_ready  = 1'b0;
    bus.ctxt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ctxt_str = {8'(8'hA0 + i), 8'(8'hB0 + i)};
      tick();
      if (i == 8) begin
        check("bp_full9",  32'(bus.fill_count), 32'd8);
        check("bp_noovf",  32'(bus.ovf), 32'd0);
      end
    end
    check("bp_fill",  32'(bus.fill_count), 32'd8);
    check("bp_ovf",   32'(bus.ovf), 32'd1);
    check("bp_head",  32'(bus.out_data), 32'hA0);

    // Clear concurrent with a drop keeps the flag, plain clear removes it
    bus.ctxt_str = 16'hEEEE;
    bus.clr_ovf  = 1'b1;
    tick();
    check("clr_drop_ovf", 32'(bus.ovf), 32'd1);
    check("clr_drop_fill", 32'(bus.fill_count), 32'd8);
    bus.ctxt_ready = 1'b0;
    tick();
    check("clr_ovf", 32'(bus.ovf), 32'd0);
    bus.clr_ovf = 1'b0;

    // Full FIFO with push on the same edge as a pop
    bus.out_ready = 1'b1;
    tick();
    check("fp_lo", 32'(bus.out_data), 32'hB0);
`ifdef RST_SER_SEPARATOR_EN
    tick();
    check("fp_sep", 32'(bus.out_data), 32'h20);
`endif
    bus.ctxt_ready = 1'b1;
    bus.ctxt_str   = 16'h5A5B;
    tick();
    bus.ctxt_ready = 1'b0;
    check("fp_fill", 32'(bus.fill_count), 32'd8);
    check("fp_ovf",  32'(bus.ovf), 32'd0);
    for (int i = 1; i < 9; i++) add_pair({8'(8'hA0 + i), 8'(8'hB0 + i)});
    add_pair(16'h5A5B);
    collect("drain", 4);
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset while in LO with three pairs queued
    bus.out_ready  = 1'b0;
    bus.ctxt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ctxt_str = {8'(8'h11 * (i + 1)), 8'(8'h11 * (i + 1) + 1)};
      tick();
    end
    bus.ctxt_ready = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    bus.out_ready  = 1'b0;
    check("ar_lo",   32'(bus.out_data), 32'h12);
    check("ar_fill", 32'(bus.fill_count), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.out_valid), 32'd0);
    check("ar_fill0", 32'(bus.fill_count), 32'd0);
    check("ar_empty", 32'(bus.empty), 32'd1);
    tick();
    rst = 1'b0;
    bus.out_ready  = 1'b1;
    bus.ctxt_ready = 1'b1;
    bus.ctxt_str   = 16'h4142;
    tick();
    bus.ctxt_ready = 1'b0;
    add_pair(16'h4142);
    collect("post", 4);
    check("post_empty", 32'(bus.empty), 32'd1);
    check("post_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_ctxt_serializer.md
# rst_ctxt_serializer

Downstream stage of the RST cipher core. It captures each 16-bit ciphertext pair the cipher produces (strobed by `ctxt_ready`) into a small FIFO. It then emits the pair as a byte stream over a valid/ready handshake, high byte first. The result is a byte-oriented ciphertext interface for the transmit/output logic. The FIFO absorbs back-pressure, and a sticky flag reports dropped pairs.

## Interface
- `DEPTH`, default 8: FIFO entries (16-bit each); power of two, ≥2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of `fill_count`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `ctxt_str`  in  16  ciphertext pair from cipher; [15:8] row char, [7:0] column char.
- `ctxt_ready`  in  1  per-cycle strobe: one pair offered in every cycle it is high.
- `out_data`  out  8  current output byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts byte when `out_valid && out_ready`.
- `fill_count`  out  CNT_W  pairs stored in FIFO (excludes pair in output stage).
- `empty`  out  1  FIFO empty and output FSM in IDLE.
- `ovf`  out  1  sticky: a pair was dropped.
- `clr_ovf`  in  1  synchronous clear of `ovf`.

## Operation
- FIFO: circular buffer, write/read pointers wrap modulo DEPTH. `fill_count` is tracked separately (range 0..DEPTH).
- Push: `ctxt_ready` high and (`fill_count < DEPTH` or a pop occurs in the same cycle). Otherwise the pair is discarded and `ovf` is set.
- Simultaneous push and pop: both take effect; `fill_count` is unchanged.
- Output FSM states: IDLE, HI, LO, plus SEP when the `_EN` macro is defined.
  - IDLE: if FIFO is non-empty, pop the head into the holding register and go to HI.
  - HI: drive `hold[15:8]`. On handshake, go to LO.
  - LO: drive `hold[7:0]`. On handshake:
    - with macro: go to SEP.
    - without macro: if FIFO is non-empty, pop and go to HI; else go to IDLE.
  - SEP: drive 8'h20. On handshake: pop→HI if non-empty, else IDLE.
- `out_valid` = state ∈ {HI, LO, SEP}. `out_data` and `out_valid` are held stable until the handshake.
- `ovf`: set wins over `clr_ovf` in the same cycle.
- Reset mid-operation: FIFO contents and the byte in flight are discarded immediately (async).

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=8'h00, `fill_count`=0, `empty`=1, `ovf`=0.
  - FSM=IDLE, pointers=0.
- All outputs are registered.
- Latency: pair strobed at edge t is written at t. IDLE pops at edge t+1. `out_valid` is high after edge t+1 with the high byte.
- Throughput: 1 byte/cycle with `out_ready` held high. There is no bubble between consecutive pairs (LO→HI direct), or between SEP→HI with the macro.
- `out_ready` low: state holds. The FIFO keeps accepting pairs until `fill_count`=DEPTH.
- Full, with a pop in the same edge, and `ctxt_ready` high: the push is accepted and `ovf` is not set.
- Empty with `ctxt_ready` high in IDLE: no same-cycle bypass. Latency stays as above.
- `empty` is deasserted the cycle after the first push.

## Configuration
- `RST_SER_SEPARATOR_EN` defined: the SEP state is compiled in, and byte 8'h20 (space) is emitted after every pair. Each pair costs 3 handshakes.
- Not defined: the SEP state and its logic are absent. Each pair costs exactly 2 handshakes.

## Test plan
- Reset, then one strobe `ctxt_str`=16'h6162 with `out_ready`=1:
  - bytes 8'h61 then 8'h62 on consecutive cycles; with the macro, 8'h20 follows.
  - `empty` then returns to 1.
- Back-to-back strobes 16'h6162, 16'h6768, 16'h3031 with `out_ready`=1: continuous stream 61 62 67 68 30 31, no idle cycle (separators interleaved if the macro is on).
- `out_ready`=0, 10 strobes with DEPTH=8:
  - first pair goes to the output stage, next 8 fill the FIFO (`fill_count`=8), 10th is dropped.
  - `ovf`=1; after release, 9 pairs are emitted in order.
- Full FIFO, `ctxt_ready` on the same edge as a pop: push accepted, `fill_count` stays 8, `ovf` remains 0.
- `ovf`=1: assert `clr_ovf` → 0 next cycle. `clr_ovf` together with a drop → `ovf` stays 1.
- Assert `rst` asynchronously while in LO with 3 pairs queued: `out_valid` drops immediately, `fill_count`=0, `empty`=1. The next strobe is emitted normally.
